// File: rtl/edm_pkg.sv
// edm_pkg: shared state encoding, gate bit positions and default timing for the discharge pulse path
package edm_pkg;
    typedef enum logic [2:0] {IDLE, GAP, TON, DEION, TOFF} state_e;
    localparam int UPPER       = 1;
    localparam int LOWER       = 0;
    localparam int DEF_CNT_W   = 16;
    localparam int DEF_DEAD_T  = 10;
    localparam int DEF_DEION_T = 20;
endpackage

// File: rtl/phase_timer.sv
// phase_timer: loadable down-counter; done marks the last cycle of the loaded phase length
module phase_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);
    logic [W-1:0] cnt_d, cnt_q;
    assign done = cnt_q <= W'(1);
    // reload on phase entry, otherwise count down and park at zero
    always_comb cnt_d = load ? load_val : (cnt_q != '0 ? cnt_q - 1'b1 : cnt_q);
    // counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/discharge_pulse_gen.sv
// discharge_pulse_gen: EDM Ton/Toff pulse train over round-robin buck channels with dead time and deionisation
module discharge_pulse_gen
    import edm_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int N_CH    = 2,
    parameter int DEAD_T  = DEF_DEAD_T,
    parameter int DEION_T = DEF_DEION_T
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic [CNT_W-1:0]  ton,
    input  logic [CNT_W-1:0]  toff,
    input  logic              param_load,
    input  logic              short_flag,
    output logic [2*N_CH-1:0] mosfet_buck,
    output logic              mosfet_deion,
    output logic              running,
    output logic [15:0]       pulse_cnt,
    output logic [7:0]        short_cnt
);
    localparam int CH_W = N_CH > 1 ? $clog2(N_CH) : 1;
    localparam int BW   = 2 * N_CH;
    state_e            state_d, state_q;
    logic [CH_W-1:0]   ch_d, ch_q;
    logic [CNT_W-1:0]  ton_sh_d, ton_sh_q, toff_sh_d, toff_sh_q;
    logic [CNT_W-1:0]  ton_act_d, ton_act_q, toff_act_d, toff_act_q;
    logic              stop_pend_d, stop_pend_q, running_d, running_q, deion_d, deion_q;
    logic [BW-1:0]     buck_d, buck_q;
    logic [15:0]       pulse_cnt_d, pulse_cnt_q;
    logic [7:0]        short_cnt_d, short_cnt_q;
    logic              tmr_load, tmr_done, gap_entry;
    logic [CNT_W-1:0]  tmr_val, ton_len, toff_len;

    assign ton_len      = ton_act_q == '0 ? CNT_W'(1) : ton_act_q;
    assign toff_len     = toff_act_q == '0 ? CNT_W'(1) : toff_act_q;
    assign mosfet_buck  = buck_q;
    assign mosfet_deion = deion_q;
    assign running      = running_q;
    assign pulse_cnt    = pulse_cnt_q;
    assign short_cnt    = short_cnt_q;

    phase_timer #(.W(CNT_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    // phase sequencing, stop handling, statistics and next registered gate pattern
    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        stop_pend_d = stop_pend_q;
        pulse_cnt_d = pulse_cnt_q;
        short_cnt_d = short_cnt_q;
        ton_sh_d    = param_load ? ton : ton_sh_q;
        toff_sh_d   = param_load ? toff : toff_sh_q;
        case (state_q)
            IDLE:    state_d = start && !stop ? GAP : IDLE;
            GAP:     state_d = stop ? IDLE : tmr_done ? TON : GAP;
            TON: begin
                stop_pend_d = stop_pend_q | stop;
                state_d     = short_flag || tmr_done || stop ? DEION : TON;
                if (short_flag) short_cnt_d = short_cnt_q == 8'hFF ? short_cnt_q : short_cnt_q + 8'd1;
                else if (tmr_done) pulse_cnt_d = pulse_cnt_q + 16'd1;
            end
            DEION: begin
                stop_pend_d = stop_pend_q | stop;
                state_d     = !tmr_done ? DEION : (stop_pend_q | stop) ? IDLE : TOFF;
            end
            TOFF: begin
                state_d = stop ? IDLE : tmr_done ? GAP : TOFF;
                if (!stop && tmr_done) ch_d = ch_q == CH_W'(N_CH - 1) ? '0 : ch_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
        if (state_d == IDLE) stop_pend_d = 1'b0;
        gap_entry  = state_d == GAP && state_q != GAP;
        ton_act_d  = gap_entry ? ton_sh_q : ton_act_q;
        toff_act_d = gap_entry ? toff_sh_q : toff_act_q;
        tmr_load   = state_d != state_q;
        tmr_val    = state_d == GAP   ? CNT_W'(DEAD_T) :
                     state_d == TON   ? ton_len :
                     state_d == DEION ? CNT_W'(DEION_T) : toff_len;
        running_d  = state_d != IDLE;
        deion_d    = state_d == DEION;
        buck_d     = state_d == TON  ? BW'(1) << (2 * ch_d + UPPER) :
                     state_d == TOFF ? BW'(1) << (2 * ch_d + LOWER) : '0;
    end

    // state, shadow/active parameters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ch_q        <= '0;
            ton_sh_q    <= CNT_W'(1);
            toff_sh_q   <= CNT_W'(1);
            ton_act_q   <= CNT_W'(1);
            toff_act_q  <= CNT_W'(1);
            stop_pend_q <= 1'b0;
            running_q   <= 1'b0;
            deion_q     <= 1'b0;
            buck_q      <= '0;
            pulse_cnt_q <= '0;
            short_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            ton_sh_q    <= ton_sh_d;
            toff_sh_q   <= toff_sh_d;
            ton_act_q   <= ton_act_d;
            toff_act_q  <= toff_act_d;
            stop_pend_q <= stop_pend_d;
            running_q   <= running_d;
            deion_q     <= deion_d;
            buck_q      <= buck_d;
            pulse_cnt_q <= pulse_cnt_d;
            short_cnt_q <= short_cnt_d;
        end
    end
endmodule
